bus_xfer_decoder: RTL and testbench

Sequenced register-transfer controller for the datapath bus. It accepts a source/destination register index pair over a valid/ready handshake and decodes each 5-bit index into 32-bit one-hot enables. It drives `bus_out_en` (source onto bus) for a programmable number of cycles, then pulses `bus_in_en` (destination latches bus). It is the decode side of the bus-select path: its `bus_out_en` is the one-hot vector the bus-select encoder converts back to a 5-bit mux select.

---
 rtl/bus_xfer_decoder.sv | 152 +++++++++++++++
 tb/tb_bus_xfer_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_decoder.sv
// bus_xfer_decoder
//
// Sequenced register-transfer controller for the datapath bus. A source /
// destination index pair is accepted over a valid/ready handshake. The source
// is then driven onto the bus for DRIVE_CYCLES cycles, after which the
// destination load enable is pulsed together with the source drive. The
// transfer finishes with a one-cycle done pulse. Illegal indices are rejected
// with a one-cycle err pulse.
//
// Parameters:
//   N_REGS       number of implemented bus endpoints (1..32)
//   DRIVE_CYCLES cycles the source drives before the destination latches (1..15)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_ready    idle and able to accept
//   src_idx      source register index
//   dst_idx      destination register index
//   bus_out_en   one-hot source drive enable
//   bus_in_en    one-hot destination load enable
//   done         one-cycle pulse, transfer complete
//   err          one-cycle pulse, illegal index rejected
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | ready for a request, all enables low
// DRIVE  | source drives the bus, counter runs down to 0
// LATCH  | source still drives, destination loads
// DONE   | done pulse, enables low
// ERR    | err pulse after an illegal index, enables low

module bus_xfer_decoder #(
    parameter int N_REGS       = 32,
    parameter int DRIVE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  src_idx,
    input  logic [4:0]  dst_idx,
    output logic [31:0] bus_out_en,
    output logic [31:0] bus_in_en,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_LATCH,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0]  CNT_LOAD  = 4'(DRIVE_CYCLES - 1);
    localparam logic [5:0]  IDX_LIMIT = 6'(N_REGS);
    localparam logic [63:0] MASK_WIDE = (64'd1 << N_REGS) - 64'd1;
    localparam logic [31:0] IMPL_MASK = MASK_WIDE[31:0];

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [4:0] src_q;
    logic [4:0] src_nxt;
    logic [4:0] dst_q;
    logic [4:0] dst_nxt;
    logic       rdy_q;
    logic       accept;
    logic       idx_bad;
    logic [31:0] src_dec;
    logic [31:0] dst_dec;

    // rdy_q holds req_ready low during reset and releases it one cycle after
    // reset drops, keeping req_ready a pure function of registered state.
    assign req_ready = (state == S_IDLE) && rdy_q;
    assign accept    = req_valid && req_ready;
    assign idx_bad   = ({1'b0, src_idx} >= IDX_LIMIT) || ({1'b0, dst_idx} >= IDX_LIMIT);

    // Mask keeps unimplemented endpoints dark even if a latched index were out of range.
    assign src_dec = (32'd1 << src_q) & IMPL_MASK;
    assign dst_dec = (32'd1 << dst_q) & IMPL_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            src_q <= 5'd0;
            dst_q <= 5'd0;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            src_q <= src_nxt;
            dst_q <= dst_nxt;
            rdy_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        src_nxt   = src_q;
        dst_nxt   = dst_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    src_nxt = src_idx;
                    dst_nxt = dst_idx;
                    if (idx_bad) begin
                        state_nxt = S_ERR;
                    end else begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_LATCH;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_LATCH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus_out_en = 32'd0;
        bus_in_en  = 32'd0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_DRIVE: bus_out_en = src_dec;
            S_LATCH: begin
                bus_out_en = src_dec;
                bus_in_en  = dst_dec;
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_xfer_decoder.sv
// Bench for bus_xfer_decoder. Three instances cover the parameter sets of
// interest: A (32 regs, 1 drive cycle), B (32 regs, 3 drive cycles),
// C (24 regs, 1 drive cycle). A timeline model predicts every output from the
// cycle offset since each accepted request.

module tb_bus_xfer_decoder;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [ND];
    logic        req_ready  [ND];
    logic [4:0]  src_idx    [ND];
    logic [4:0]  dst_idx    [ND];
    logic [31:0] bus_out_en [ND];
    logic [31:0] bus_in_en  [ND];
    logic        done       [ND];
    logic        err        [ND];

    int nr [ND];
    int dc [ND];

    // timeline model state
    bit m_busy [ND];
    bit m_rstq [ND];
    bit m_bad  [ND];
    int m_k    [ND];
    int m_s    [ND];
    int m_d    [ND];
    int cyc;

    int nchecks = 0;
    int nfail   = 0;

    always #5 clk = ~clk;

    bus_xfer_decoder #(.N_REGS(32), .DRIVE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .src_idx(src_idx[0]), .dst_idx(dst_idx[0]), .bus_out_en(bus_out_en[0]),
        .bus_in_en(bus_in_en[0]), .done(done[0]), .err(err[0]));

    bus_xfer_decoder #(.N_REGS(32), .DRIVE_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .src_idx(src_idx[1]), .dst_idx(dst_idx[1]), .bus_out_en(bus_out_en[1]),
        .bus_in_en(bus_in_en[1]), .done(done[1]), .err(err[1]));

    bus_xfer_decoder #(.N_REGS(24), .DRIVE_CYCLES(1)) dut_c (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .src_idx(src_idx[2]), .dst_idx(dst_idx[2]), .bus_out_en(bus_out_en[2]),
        .bus_in_en(bus_in_en[2]), .done(done[2]), .err(err[2]));

    // Expected {req_ready, done, err, bus_out_en, bus_in_en} for the current cycle.
    // k counts cycles since the accept edge: 1..DC drive, DC+1 latch, DC+2 done.
    function automatic logic [66:0] exp_bundle(int d);
        logic        r, dn, er;
        logic [31:0] o, i;
        r = 1'b0; dn = 1'b0; er = 1'b0; o = '0; i = '0;
        if (!m_rstq[d]) begin
            if (!m_busy[d]) begin
                r = 1'b1;
            end else if (m_bad[d]) begin
                er = (m_k[d] == 1);
            end else begin
                if (m_k[d] <= dc[d] + 1) o = 32'd1 << m_s[d];
                if (m_k[d] == dc[d] + 1) i = 32'd1 << m_d[d];
                if (m_k[d] == dc[d] + 2) dn = 1'b1;
            end
        end
        return {r, dn, er, o, i};
    endfunction

    function automatic logic [66:0] obs_bundle(int d);
        return {req_ready[d], done[d], err[d], bus_out_en[d], bus_in_en[d]};
    endfunction

    // Advance one clock and move the model along; no checking here.
    task automatic tick();
        bit acc [ND];
        int cs  [ND];
        int cd  [ND];
        for (int d = 0; d < ND; d++) begin
            acc[d] = !rst && !m_rstq[d] && !m_busy[d] && (req_valid[d] === 1'b1);
            cs[d]  = int'(src_idx[d]);
            cd[d]  = int'(dst_idx[d]);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_busy[d] = 1'b0;
                m_rstq[d] = 1'b1;
            end else begin
                m_rstq[d] = 1'b0;
                if (acc[d]) begin
                    m_busy[d] = 1'b1;
                    m_k[d]    = 1;
                    m_s[d]    = cs[d];
                    m_d[d]    = cd[d];
                    m_bad[d]  = (cs[d] >= nr[d]) || (cd[d] >= nr[d]);
                end else if (m_busy[d]) begin
                    m_k[d]++;
                    if (m_bad[d] ? (m_k[d] >= 2) : (m_k[d] >= dc[d] + 3)) m_busy[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0;
            src_idx[d]   = 5'd0;
            dst_idx[d]   = 5'd0;
        end
    endtask

    task automatic test_reset();
        logic [66:0] e, o;
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b1;
            src_idx[d]   = 5'd3;
            dst_idx[d]   = 5'd5;
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 2) rst = 1'b0;
            tick();
            for (int d = 0; d < ND; d++) begin
                e = exp_bundle(d);
                o = obs_bundle(d);
                nchecks++;
                if (o !== e) begin
                    nfail++;
                    $display("FAIL reset dut%0d cyc%0d: got %h expected %h", d, cyc, o, e);
                end
            end
        end
        // c=2: ready after deassert; c=3: request accepted, src 3 driven
        for (int d = 0; d < ND; d++) begin
            nchecks++;
            if (bus_out_en[d] !== 32'h8) begin
                nfail++;
                $display("FAIL reset_accept dut%0d: bus_out_en got %h expected 00000008", d, bus_out_en[d]);
            end
        end
        idle_all();
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                e = exp_bundle(d);
                o = obs_bundle(d);
                nchecks++;
                if (o !== e) begin
                    nfail++;
                    $display("FAIL reset_drain dut%0d cyc%0d: got %h expected %h", d, cyc, o, e);
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [66:0] e, o;
        req_valid[0] = 1'b1; src_idx[0] = 5'd3; dst_idx[0] = 5'd17;
        tick();
        idle_all();
        for (int k = 1; k <= 4; k++) begin
            e = exp_bundle(0);
            o = obs_bundle(0);
            nchecks++;
            if (o !== e) begin
                nfail++;
                $display("FAIL basic k=%0d: got %h expected %h", k, o, e);
            end
            if (k == 2) begin
                nchecks++;
                if (bus_in_en[0] !== 32'h0002_0000) begin
                    nfail++;
                    $display("FAIL basic_latch: bus_in_en got %h expected 00020000", bus_in_en[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_drive3();
        logic [66:0] e, o;
        int pairs [2][2] = '{'{31, 0}, '{9, 9}};
        for (int p = 0; p < 2; p++) begin
            req_valid[1] = 1'b1;
            src_idx[1] = 5'(pairs[p][0]);
            dst_idx[1] = 5'(pairs[p][1]);
            tick();
            idle_all();
            for (int k = 1; k <= 6; k++) begin
                e = exp_bundle(1);
                o = obs_bundle(1);
                nchecks++;
                if (o !== e) begin
                    nfail++;
                    $display("FAIL drive3 pair%0d k=%0d: got %h expected %h", p, k, o, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_illegal();
        logic [66:0] e, o;
        int pairs [4][2] = '{'{24, 2}, '{2, 30}, '{31, 31}, '{23, 23}};
        for (int p = 0; p < 4; p++) begin
            req_valid[2] = 1'b1;
            src_idx[2] = 5'(pairs[p][0]);
            dst_idx[2] = 5'(pairs[p][1]);
            tick();
            idle_all();
            for (int k = 1; k <= 4; k++) begin
                e = exp_bundle(2);
                o = obs_bundle(2);
                nchecks++;
                if (o !== e) begin
                    nfail++;
                    $display("FAIL illegal pair%0d k=%0d: got %h expected %h", p, k, o, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [66:0] e, o;
        req_valid[0] = 1'b1; src_idx[0] = 5'd4; dst_idx[0] = 5'd6;
        tick();
        idle_all();
        tick();
        // now in LATCH
        e = exp_bundle(0);
        o = obs_bundle(0);
        nchecks++;
        if (o !== e) begin
            nfail++;
            $display("FAIL reset_mid_latch: got %h expected %h", o, e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = exp_bundle(0);
            o = obs_bundle(0);
            nchecks++;
            if (o !== e) begin
                nfail++;
                $display("FAIL reset_mid k=%0d: got %h expected %h", k, o, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [66:0] e, o;
        int last_acc [ND];
        bit dut_acc  [ND];
        for (int d = 0; d < ND; d++) last_acc[d] = -1;
        for (int c = 0; c < 240; c++) begin
            for (int d = 0; d < ND; d++) begin
                req_valid[d] = 1'b1;
                src_idx[d]   = 5'($urandom_range(31, 0));
                dst_idx[d]   = 5'($urandom_range(31, 0));
                dut_acc[d]   = (req_ready[d] === 1'b1);
            end
            tick();
            for (int d = 0; d < ND; d++) begin
                e = exp_bundle(d);
                o = obs_bundle(d);
                nchecks++;
                if (o !== e) begin
                    nfail++;
                    $display("FAIL stream dut%0d cyc%0d: got %h expected %h", d, cyc, o, e);
                end
                nchecks++;
                if (!$onehot0(bus_out_en[d]) || !$onehot0(bus_in_en[d]) ||
                    (((bus_out_en[d] | bus_in_en[d]) >> nr[d]) != 32'd0) || (done[d] && err[d])) begin
                    nfail++;
                    $display("FAIL stream_invariant dut%0d cyc%0d: out=%h in=%h done=%b err=%b",
                             d, cyc, bus_out_en[d], bus_in_en[d], done[d], err[d]);
                end
                // instances A and B only see legal indices, so spacing is fixed
                if (d < 2 && dut_acc[d]) begin
                    if (last_acc[d] >= 0) begin
                        nchecks++;
                        if (cyc - last_acc[d] != dc[d] + 3) begin
                            nfail++;
                            $display("FAIL stream_spacing dut%0d: got %0d expected %0d",
                                     d, cyc - last_acc[d], dc[d] + 3);
                        end
                    end
                    last_acc[d] = cyc;
                end
            end
        end
        idle_all();
        repeat (8) tick();
    endtask

    initial begin
        nr  = '{32, 32, 24};
        dc  = '{1, 3, 1};
        cyc = 0;
        for (int d = 0; d < ND; d++) begin
            m_busy[d] = 1'b0;
            m_rstq[d] = 1'b1;
            m_bad[d]  = 1'b0;
            m_k[d]    = 0;
            m_s[d]    = 0;
            m_d[d]    = 0;
        end
        rst = 1'b1;
        idle_all();
        test_reset();
        test_basic();
        test_drive3();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
